// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end with a 2-credit request window.
//
// Issues sequential word-aligned fetch requests to instruction memory. It
// tracks the PC of every accepted request in a 2-entry in-order tag queue
// and pairs each returning instruction with its PC in a 2-entry output
// buffer. The buffer head drives the decode-facing outputs combinationally.
// A redirect from Execute flushes the buffer and silently drops the responses
// still in flight for requests made before the redirect.
//
// Handshake semantics: a request transfers in a cycle where imem_req and
// imem_ready are both 1. While imem_req=1 and imem_ready=0 the address holds,
// unless a redirect withdraws the request. Responses (imem_rvalid) have no
// back-pressure and return in request order. The decode stage consumes the
// head when validF=1 and stallF=0.
//
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   stallF              hold the presented instruction
//   redirectE/PCTargetE taken branch/jump and its target
//   imem_req/addr/ready request channel to instruction memory
//   imem_rvalid/rdata   response channel from instruction memory
//   insF/PCF/PCPlus4F   presented instruction, its PC and PC+4
//   validF              insF/PCF hold a real fetched instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirectE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
);

  // Next address to request; always word aligned.
  logic [31:0] r_next_pc;

  // In-order tag queue: PC of each outstanding request.
  logic [31:0] r_tag_pc [2];
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [1:0]  r_tag_cnt;

  // Output buffer: fetched instruction + PC pairs.
  logic [31:0] r_buf_ins [2];
  logic [31:0] r_buf_pc  [2];
  logic        r_buf_rd;
  logic        r_buf_wr;
  logic [1:0]  r_buf_cnt;

  // Responses still to be discarded after the last redirect.
  logic [1:0]  r_drop_cnt;

  logic        w_head_pop;
  logic        w_req_fire;
  logic        w_buf_push;
  logic [2:0]  w_credit_used;
  logic [1:0]  w_tag_after_pop;

  assign validF     = (r_buf_cnt != 2'd0);
  assign w_head_pop = validF && !stallF;

  // Every outstanding request will land in the buffer, so outstanding plus
  // occupancy is the number of buffer slots already spoken for. The head
  // leaving this cycle frees a slot immediately, which is what lets the
  // zero-wait steady state issue one request per cycle.
  assign w_credit_used = {1'b0, r_tag_cnt} + {1'b0, r_buf_cnt} - {2'b00, w_head_pop};
  assign imem_req      = !reset && !redirectE && (w_credit_used < 3'd2);
  assign imem_addr     = r_next_pc;
  assign w_req_fire    = imem_req && imem_ready;

  // Outstanding count once this cycle's response has left the tag queue; on
  // a redirect this is exactly how many stale responses are still to come.
  assign w_tag_after_pop = r_tag_cnt - {1'b0, imem_rvalid};
  assign w_buf_push      = imem_rvalid && (r_drop_cnt == 2'd0) && !redirectE;

  assign insF     = validF ? r_buf_ins[r_buf_rd] : NOP_INS;
  assign PCF      = validF ? r_buf_pc[r_buf_rd] : 32'h0000_0000;
  assign PCPlus4F = PCF + 32'd4;

  // Control state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_next_pc  <= RESET_PC & 32'hFFFF_FFFC;
      r_tag_rd   <= 1'b0;
      r_tag_wr   <= 1'b0;
      r_tag_cnt  <= 2'd0;
      r_buf_rd   <= 1'b0;
      r_buf_wr   <= 1'b0;
      r_buf_cnt  <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else begin
      if (redirectE) begin
        r_next_pc <= PCTargetE & 32'hFFFF_FFFC;
      end else if (w_req_fire) begin
        r_next_pc <= r_next_pc + 32'd4;
      end

      // Tag queue keeps running through a redirect: stale responses still
      // arrive and must still be popped.
      if (w_req_fire) begin
        r_tag_wr <= ~r_tag_wr;
      end
      if (imem_rvalid) begin
        r_tag_rd <= ~r_tag_rd;
      end
      r_tag_cnt <= r_tag_cnt + {1'b0, w_req_fire} - {1'b0, imem_rvalid};

      if (redirectE) begin
        r_drop_cnt <= w_tag_after_pop;
      end else if (imem_rvalid && (r_drop_cnt != 2'd0)) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end

      if (redirectE) begin
        r_buf_rd  <= 1'b0;
        r_buf_wr  <= 1'b0;
        r_buf_cnt <= 2'd0;
      end else begin
        if (w_buf_push) begin
          r_buf_wr <= ~r_buf_wr;
        end
        if (w_head_pop) begin
          r_buf_rd <= ~r_buf_rd;
        end
        r_buf_cnt <= r_buf_cnt + {1'b0, w_buf_push} - {1'b0, w_head_pop};
      end
    end
  end

  // Data storage; contents are qualified by the counters, so no reset needed.
  always_ff @(posedge CLK) begin
    if (w_req_fire) begin
      r_tag_pc[r_tag_wr] <= r_next_pc;
    end
    if (w_buf_push) begin
      r_buf_ins[r_buf_wr] <= imem_rdata;
      r_buf_pc[r_buf_wr]  <= r_tag_pc[r_tag_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A behavioural memory answers accepted requests after a fixed latency. A
// monitor checks every cycle that presented instructions match memory
// contents, that consumed PCs follow the stream requested since the last
// flush, and that request addresses advance by 4 from each flush target.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INS  = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        CLK        = 1'b0;
  logic        reset      = 1'b1;
  logic        stallF     = 1'b0;
  logic        redirectE  = 1'b0;
  logic [31:0] PCTargetE  = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready  = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic [31:0] insF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INS(NOP_INS)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .stallF     (stallF),
    .redirectE  (redirectE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .insF       (insF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .validF     (validF)
  );

  // ---------------- memory model + scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Memory controls, written by the test tasks.
  int   mem_lat    = 1;
  logic hold_nr    = 1'b0;
  logic rand_ready = 1'b0;

  logic [31:0] exp_q[$];     // PCs that must be consumed, in order
  logic [31:0] mq_addr[$];   // memory: pending response addresses
  int          mq_due[$];    // memory: cycle each response is returned
  logic [31:0] exp_addr = RESET_PC;
  logic        prev_hold = 1'b0;
  logic        prev_stall_valid = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_pc   = 32'h0;
  logic [31:0] prev_ins  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  always begin
    @(negedge CLK);
    #1;
    if (mq_due.size() != 0 && mq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
      mq_due.delete(0);
      mq_addr.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (hold_nr) imem_ready = 1'b0;
    else if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
    else imem_ready = 1'b1;
    #3;
    // presented instruction
    n_checks++;
    if (validF === 1'b1) begin
      if (insF !== mem_word(PCF) || PCPlus4F !== PCF + 32'd4) begin
        n_fail++;
        $display("FAIL sb_data: PCF=%h insF=%h PCPlus4F=%h, required insF=%h PCPlus4F=%h",
                 PCF, insF, PCPlus4F, mem_word(PCF), PCF + 32'd4);
      end
    end else if (validF !== 1'b0 || insF !== NOP_INS || PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
      n_fail++;
      $display("FAIL sb_empty: validF=%b insF=%h PCF=%h PCPlus4F=%h, required 0/%h/0/4",
               validF, insF, PCF, PCPlus4F, NOP_INS);
    end
    if (prev_stall_valid) begin
      n_checks++;
      if (validF !== 1'b1 || PCF !== prev_pc || insF !== prev_ins) begin
        n_fail++;
        $display("FAIL sb_stall_hold: validF=%b PCF=%h insF=%h, required 1/%h/%h",
                 validF, PCF, insF, prev_pc, prev_ins);
      end
    end
    if (validF === 1'b1 && !stallF && !redirectE && !reset) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_order: consumed PCF=%h, required no instruction", PCF);
      end else begin
        if (PCF !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_order: consumed PCF=%h, required %h", PCF, exp_q[0]);
        end
        exp_q.delete(0);
      end
    end
    prev_stall_valid = (validF === 1'b1) && stallF && !redirectE && !reset;
    prev_pc  = PCF;
    prev_ins = insF;
    // request channel
    if (imem_req === 1'b1) begin
      n_checks++;
      if (imem_addr[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL req_align: imem_addr=%h, required low bits 00", imem_addr);
      end
      if (prev_hold) begin
        n_checks++;
        if (imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_stable: imem_addr=%h, required %h", imem_addr, prev_addr);
        end
      end
    end
    if (reset || redirectE) begin
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL req_blocked: imem_req=%b, required 0 (reset=%b redirectE=%b)",
                 imem_req, reset, redirectE);
      end
      exp_q.delete();
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        exp_addr = RESET_PC;
      end else begin
        exp_addr = PCTargetE & 32'hFFFF_FFFC;
      end
    end else if (imem_req === 1'b1 && imem_ready) begin
      n_checks++;
      if (imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL req_addr: imem_addr=%h, required %h", imem_addr, exp_addr);
      end
      mq_addr.push_back(exp_addr);
      mq_due.push_back(cyc + mem_lat);
      exp_q.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
      n_checks++;
      if (mq_addr.size() > 2) begin
        n_fail++;
        $display("FAIL outstanding: %0d requests in flight, required at most 2", mq_addr.size());
      end
    end
    prev_hold = (imem_req === 1'b1) && !imem_ready && !reset && !redirectE;
    prev_addr = imem_addr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Holds reset for two cycles; returns at the start of the first cycle
  // with reset=0.
  task automatic do_reset(input int lat);
    @(negedge CLK);
    reset = 1'b1; stallF = 1'b0; redirectE = 1'b0;
    hold_nr = 1'b0; rand_ready = 1'b0; mem_lat = lat;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stallF = 1'b0; redirectE = 1'b0;
    hold_nr = 1'b0; rand_ready = 1'b0; mem_lat = 1;
    repeat (2) @(negedge CLK);
    #4;
    n_checks++;
    if (validF !== 1'b0 || insF !== NOP_INS || PCF !== 32'h0 || PCPlus4F !== 32'h4 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: validF=%b insF=%h PCF=%h PCPlus4F=%h imem_req=%b, required 0/%h/0/4/0",
               validF, insF, PCF, PCPlus4F, imem_req, NOP_INS);
    end
  endtask

  task automatic test_stream();
    @(negedge CLK);
    reset = 1'b0;
    #4;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: imem_req=%b imem_addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge CLK); #4;
    n_checks++;
    if (validF !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: validF=%b, required 0", validF);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #4;
      n_checks++;
      if (validF !== 1'b1 || PCF !== RESET_PC + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_pc: validF=%b PCF=%h, required 1/%h", validF, PCF, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (4) @(negedge CLK);
    stallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      n_checks++;
      if (validF !== 1'b1 || PCF !== 32'h8 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: validF=%b PCF=%h imem_req=%b, required 1/00000008/0",
                 validF, PCF, imem_req);
      end
      @(negedge CLK);
    end
    stallF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++;
      if (validF !== 1'b1 || PCF !== 32'(8 + 4 * i)) begin
        n_fail++;
        $display("FAIL stall_release: validF=%b PCF=%h, required 1/%h", validF, PCF, 32'(8 + 4 * i));
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_redirect();
    logic        got_req;
    logic        got_valid;
    logic [31:0] first_addr;
    logic [31:0] first_pc;
    logic [31:0] first_p4;
    got_req = 1'b0; got_valid = 1'b0;
    first_addr = 32'h0; first_pc = 32'h0; first_p4 = 32'h0;
    do_reset(3);
    repeat (2) @(negedge CLK);
    redirectE = 1'b1;
    PCTargetE = 32'h0000_0103;
    @(negedge CLK);
    redirectE = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      #4;
      if (!got_req && imem_req === 1'b1) begin
        got_req = 1'b1;
        first_addr = imem_addr;
      end
      if (validF === 1'b1) begin
        got_valid = 1'b1;
        first_pc = PCF;
        first_p4 = PCPlus4F;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (!got_req || first_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_addr: seen=%b imem_addr=%h, required 1/00000100", got_req, first_addr);
    end
    n_checks++;
    if (!got_valid || first_pc !== 32'h100 || first_p4 !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_first: seen=%b PCF=%h PCPlus4F=%h, required 1/00000100/00000104",
               got_valid, first_pc, first_p4);
    end
  endtask

  task automatic test_back_to_back();
    logic        got_valid;
    logic [31:0] first_pc;
    got_valid = 1'b0; first_pc = 32'h0;
    do_reset(2);
    rand_ready = 1'b1;
    repeat (6) @(negedge CLK);
    redirectE = 1'b1;
    PCTargetE = 32'h40;
    @(negedge CLK);
    PCTargetE = 32'h80;
    @(negedge CLK);
    redirectE = 1'b0;
    for (int i = 0; i < 30 && !got_valid; i++) begin
      #4;
      if (validF === 1'b1) begin
        got_valid = 1'b1;
        first_pc = PCF;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (!got_valid || first_pc !== 32'h80) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%b PCF=%h, required 1/00000080", got_valid, first_pc);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_ready_hold();
    logic seen;
    logic [31:0] first_pc;
    do_reset(1);
    repeat (5) @(negedge CLK);
    redirectE = 1'b1;
    PCTargetE = 32'h20;
    hold_nr   = 1'b1;
    @(negedge CLK);
    redirectE = 1'b0;
    #4;
    seen = (imem_req === 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK); #4;
      seen = (imem_req === 1'b1);
    end
    n_checks++;
    if (!seen || imem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL hold_req: seen=%b imem_addr=%h, required 1/00000020", seen, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #4;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
        n_fail++;
        $display("FAIL hold_addr: imem_req=%b imem_addr=%h, required 1/00000020", imem_req, imem_addr);
      end
    end
    @(negedge CLK);
    hold_nr = 1'b0;
    #4;
    n_checks++;
    if (imem_req !== 1'b1 || imem_ready !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL hold_accept: imem_req=%b imem_ready=%b imem_addr=%h, required 1/1/00000020",
               imem_req, imem_ready, imem_addr);
    end
    repeat (4) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    #4;
    n_checks++;
    if (validF !== 1'b0 || insF !== NOP_INS || PCF !== 32'h0 || PCPlus4F !== 32'h4 ||
        imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL mid_reset: validF=%b insF=%h PCF=%h PCPlus4F=%h req=%b addr=%h, required 0/%h/0/4/1/%h",
               validF, insF, PCF, PCPlus4F, imem_req, imem_addr, NOP_INS, RESET_PC);
    end
    seen = 1'b0; first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK); #4;
      if (validF === 1'b1) begin
        seen = 1'b1;
        first_pc = PCF;
      end
    end
    n_checks++;
    if (!seen || first_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL restart_pc: seen=%b PCF=%h, required 1/%h", seen, first_pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [3];
    logic [31:0] p4s [3];
    int n;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      pcs[k] = 32'h1; p4s[k] = 32'h1;
    end
    do_reset(1);
    redirectE = 1'b1;
    PCTargetE = 32'hFFFF_FFF8;
    @(negedge CLK);
    redirectE = 1'b0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge CLK); #4;
      if (validF === 1'b1) begin
        pcs[n] = PCF;
        p4s[n] = PCPlus4F;
        n++;
      end
    end
    n_checks++;
    if (n != 3 || pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_seq: count=%0d PCF=%h,%h,%h, required 3 fffffff8,fffffffc,00000000",
               n, pcs[0], pcs[1], pcs[2]);
    end
    n_checks++;
    if (p4s[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_plus4: PCPlus4F=%h, required 00000000", p4s[1]);
    end
  endtask

  task automatic test_random();
    int consumed;
    consumed = 0;
    for (int ph = 0; ph < 4; ph++) begin
      do_reset($urandom_range(1, 3));
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
        stallF    = ($urandom_range(0, 3) == 0);
        redirectE = ($urandom_range(0, 19) == 0);
        PCTargetE = $urandom;
        #4;
        if (validF === 1'b1 && !stallF && !redirectE) consumed++;
        @(negedge CLK);
      end
      stallF = 1'b0;
      redirectE = 1'b0;
      repeat (10) @(negedge CLK);
    end
    rand_ready = 1'b0;
    n_checks++;
    if (consumed < 50) begin
      n_fail++;
      $display("FAIL random_progress: consumed=%0d, required at least 50", consumed);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_ready_hold();
    test_wrap();
    test_random();
    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
